// File: rtl/coax_line_controller.sv
// Half-duplex coax line sequencer.
// Decides whether the transmitter or the receiver owns the line. After each
// transmission it blanks the receiver for a fixed turnaround, then optionally
// opens a response window. It enforces a minimum idle gap before the next grant.
//
// Handshake: the host raises tx_request and holds it until tx_grant is seen.
// tx_grant is a level that stays high while the transmitter owns the line.
// response_start and response_timeout are single-cycle pulses. Each pulse is
// high in the first cycle of the state it leads into.
module coax_line_controller #(
    parameter int TURNAROUND_CLOCKS       = 8,
    parameter int RESPONSE_TIMEOUT_CLOCKS = 1200,
    parameter int GAP_CLOCKS              = 4,
    parameter int COUNTER_WIDTH           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_request,
    input  logic       expect_response,
    input  logic       tx_active,
    input  logic       rx_active,
    input  logic       rx_frame_done,
    output logic       tx_grant,
    output logic       rx_enable,
    output logic       blank_enable,
    output logic       response_start,
    output logic       response_timeout,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TX         = 3'd1,
        S_TURNAROUND = 3'd2,
        S_WAIT_RESP  = 3'd3,
        S_RX         = 3'd4,
        S_GAP        = 3'd5
    } state_t;

    // Each timed state loads N-1 on entry and exits when the count reaches 0.
    // This makes the state last exactly N cycles.
    localparam logic [COUNTER_WIDTH-1:0] LP_TURN_LOAD = COUNTER_WIDTH'(TURNAROUND_CLOCKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] LP_RESP_LOAD = COUNTER_WIDTH'(RESPONSE_TIMEOUT_CLOCKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] LP_GAP_LOAD  = COUNTER_WIDTH'(GAP_CLOCKS - 1);

    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_expect;
    logic                     r_seen_tx;
    logic                     r_response_start;
    logic                     r_response_timeout;
    logic                     w_count_zero;

    assign w_count_zero = (r_count == '0);

    // Sequencer: state, shared down-counter, expect latch, seen_tx flag and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_count            <= '0;
            r_expect           <= 1'b0;
            r_seen_tx          <= 1'b0;
            r_response_start   <= 1'b0;
            r_response_timeout <= 1'b0;
        end else begin
            r_response_start   <= 1'b0;
            r_response_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // When both arrive together the receiver wins; the request stays pending.
                    if (rx_active) begin
                        r_state <= S_RX;
                    end else if (tx_request) begin
                        r_state   <= S_TX;
                        r_expect  <= expect_response;
                        r_seen_tx <= 1'b0;
                    end
                end
                S_TX: begin
                    if (tx_active) begin
                        r_seen_tx <= 1'b1;
                    end
                    if (!tx_active && r_seen_tx) begin
                        r_state <= S_TURNAROUND;
                        r_count <= LP_TURN_LOAD;
                    end else if (!tx_request && !r_seen_tx && !tx_active) begin
                        // The host withdrew before sending anything, so no response window opens.
                        r_state <= S_GAP;
                        r_count <= LP_GAP_LOAD;
                    end
                end
                S_TURNAROUND: begin
                    // A transmitter that keeps driving restarts the blanking period.
                    if (tx_active) begin
                        r_count <= LP_TURN_LOAD;
                    end else if (w_count_zero) begin
                        if (r_expect) begin
                            r_state <= S_WAIT_RESP;
                            r_count <= LP_RESP_LOAD;
                        end else begin
                            r_state <= S_GAP;
                            r_count <= LP_GAP_LOAD;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_WAIT_RESP: begin
                    // rx_active takes priority, so activity on the last count is still a response.
                    if (rx_active) begin
                        r_state          <= S_RX;
                        r_response_start <= 1'b1;
                    end else if (w_count_zero) begin
                        r_state            <= S_GAP;
                        r_count            <= LP_GAP_LOAD;
                        r_response_timeout <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_RX: begin
                    if (rx_frame_done) begin
                        r_state <= S_GAP;
                        r_count <= LP_GAP_LOAD;
                    end
                end
                S_GAP: begin
                    // A frame arriving during the gap is received, and the gap starts again afterwards.
                    if (rx_active) begin
                        r_state <= S_RX;
                    end else if (w_count_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        tx_grant     = (r_state == S_TX);
        blank_enable = (r_state == S_TX) || (r_state == S_TURNAROUND);
        rx_enable    = !blank_enable;
        busy         = (r_state != S_IDLE);
    end

    assign response_start   = r_response_start;
    assign response_timeout = r_response_timeout;
    assign state            = r_state;

endmodule

// File: doc/coax_line_controller.md
Name: coax_line_controller

Overview:
Half-duplex line sequencer for the coax interface. It arbitrates between the transmitter and the receiver, grants the line to the transmitter, and enforces a receive-blank turnaround after each transmission. It times the response window and enforces a minimum idle gap before the next transmission. It sits between the host command logic, the coax transmitter and the RX path, and drives the RX blanker enable and the receiver enable.

Parameters:
TURNAROUND_CLOCKS, 8, cycles RX stays disabled and blanked after tx_active falls (≥1)
RESPONSE_TIMEOUT_CLOCKS, 1200, cycles to wait for rx_active after turnaround when a response is expected (≥1)
GAP_CLOCKS, 4, minimum cycles between end of any line activity and next tx_grant (≥1)
COUNTER_WIDTH, 16, width of the shared down-counter; every *_CLOCKS value must be ≤ 2^COUNTER_WIDTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tx_request  in  1  level; host wants to transmit; held until tx_grant is seen
expect_response  in  1  sampled on the cycle tx_grant rises; 1 = open response window after TX
tx_active  in  1  transmitter is driving the line
rx_active  in  1  receiver has detected frame activity
rx_frame_done  in  1  single-cycle pulse; receiver finished a frame (good or error)
tx_grant  out  1  level; transmitter may start/continue
rx_enable  out  1  receiver may accept data
blank_enable  out  1  drives the RX blanker enable
response_start  out  1  single-cycle pulse; rx_active seen inside response window
response_timeout  out  1  single-cycle pulse; response window expired
busy  out  1  state != IDLE
state  out  3  debug encoding: IDLE=0, TX=1, TURNAROUND=2, WAIT_RESP=3, RX=4, GAP=5

Behaviour:
- Moore FSM. tx_grant, rx_enable, blank_enable, busy and state decode the state register. The two pulses are registered and assert in the cycle the new state is first held.
- Reset: state IDLE, counter 0, expect latch 0, seen_tx 0. Outputs: tx_grant 0, rx_enable 1, blank_enable 0, busy 0, both pulses 0. Reset mid-operation aborts immediately, with no pulses and no gap.
- Counter: loaded with N-1 on state entry. The state exits on the cycle the counter reads 0, so it lasts exactly N cycles.
- IDLE: rx_enable=1.
  - rx_active → RX.
  - Else tx_request → TX; latch expect_response; clear seen_tx.
  - rx_active and tx_request in the same cycle: RX wins; the request stays pending.
- TX: tx_grant=1, blank_enable=1, rx_enable=0. Set seen_tx when tx_active=1.
  - tx_active=0 with seen_tx=1 → TURNAROUND.
  - tx_request drops while seen_tx=0 → GAP (abort; no response window).
  - rx_active is ignored in TX.
- TURNAROUND: blank_enable=1, rx_enable=0, tx_grant=0; lasts TURNAROUND_CLOCKS.
  - At expiry: expect latch=1 → WAIT_RESP, else → GAP.
  - tx_active re-asserting here is a protocol error: restart the TURNAROUND count; no grant.
- WAIT_RESP: rx_enable=1, blank_enable=0; lasts up to RESPONSE_TIMEOUT_CLOCKS.
  - rx_active → RX and pulse response_start.
  - Counter 0 without rx_active → GAP and pulse response_timeout.
  - rx_active on the final count cycle counts as a response: no timeout.
- RX: rx_enable=1.
  - rx_frame_done → GAP.
  - rx_frame_done on the RX entry cycle is honoured.
- GAP: rx_enable=1; lasts GAP_CLOCKS.
  - rx_active → RX; the gap restarts after that frame.
  - At expiry → IDLE.
  - tx_request during GAP is held off; tx_grant can first rise GAP_CLOCKS+1 cycles after GAP entry (GAP, then IDLE).
- Pulses never assert in the same cycle. Unused state encodings recover to IDLE.

Test Plan:
- Basic TX, no response: tx_request=1, expect_response=0; tx_active high 20 cycles → tx_grant rises 1 cycle after request; 8 cycles rx_enable=0 and blank_enable=1 after tx_active falls; 4 GAP cycles; busy=0; no pulses.
- Response received: expect_response=1; rx_active 100 cycles into WAIT_RESP → response_start single pulse; state RX; rx_frame_done → GAP → IDLE after 4 cycles.
- Timeout: expect_response=1, RESPONSE_TIMEOUT_CLOCKS=16, no rx_active → exactly 16 WAIT_RESP cycles; response_timeout pulse once; then GAP.
- Boundary: rx_active on the last WAIT_RESP cycle → response_start=1, response_timeout stays 0.
- Collision/priority: rx_active and tx_request both asserted in IDLE → RX, tx_grant=0. After rx_frame_done plus 4 GAP cycles and 1 IDLE cycle, tx_grant=1.
- Abort and reset: drop tx_request in TX before tx_active → GAP, no TURNAROUND. Separately, assert reset during TURNAROUND → next cycle state=0, rx_enable=1, blank_enable=0, no pulses.
